// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail, accepts out-of-order writeback by index,
// retires in program order from the head and raises a flush on a mispredict or exception.
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int PREG_W = 6,
   parameter int AREG_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [AREG_W-1:0] alloc_dst_areg,
   input  logic [PREG_W-1:0] alloc_dst_preg,
   input  logic [PREG_W-1:0] alloc_old_preg,
   input  logic [31:0]       alloc_pc,
   output logic [IDX_W-1:0]  alloc_idx,
   input  logic              ex_valid,
   input  logic [IDX_W-1:0]  rob_entry_idx,
   input  logic [31:0]       ex_val,
   input  logic              br_mispred,
   input  logic              exception,
   output logic              commit_valid,
   output logic [AREG_W-1:0] commit_dst_areg,
   output logic [PREG_W-1:0] commit_dst_preg,
   output logic [PREG_W-1:0] commit_old_preg,
   output logic              flush_valid,
   output logic [31:0]       flush_target,
   output logic [IDX_W:0]    count
);

   // Handshake: an entry is allocated at a rising edge exactly when alloc_valid && alloc_ready;
   // alloc_ready depends only on registered state, never on alloc_valid.
   localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

   logic [DEPTH-1:0]  valid_q, done_q, mispred_q, exc_q;
   logic [AREG_W-1:0] areg_q     [DEPTH];
   logic [PREG_W-1:0] preg_q     [DEPTH];
   logic [PREG_W-1:0] old_preg_q [DEPTH];
   logic [31:0]       pc_q       [DEPTH];
   logic [31:0]       val_q      [DEPTH];

   // Pointers carry an extra wrap bit to tell full from empty.
   logic [IDX_W:0]    head, tail;
   logic [IDX_W-1:0]  head_idx, tail_idx;
   logic              full, head_ready, alloc_fire;

   assign head_idx   = head[IDX_W-1:0];
   assign tail_idx   = tail[IDX_W-1:0];
   assign full       = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
   assign count      = tail - head;
   assign head_ready = valid_q[head_idx] && done_q[head_idx];
   assign alloc_idx  = tail_idx;

   always_comb begin
      commit_valid    = 1'b0;
      flush_valid     = 1'b0;
      commit_dst_areg = '0;
      commit_dst_preg = '0;
      commit_old_preg = '0;
      flush_target    = '0;
      if (head_ready) begin
         if (exc_q[head_idx]) begin
            // A faulting instruction is not retired; execution restarts at its own PC.
            flush_valid  = 1'b1;
            flush_target = pc_q[head_idx];
         end else begin
            commit_valid    = 1'b1;
            commit_dst_areg = areg_q[head_idx];
            commit_dst_preg = preg_q[head_idx];
            commit_old_preg = old_preg_q[head_idx];
            if (mispred_q[head_idx]) begin
               flush_valid  = 1'b1;
               flush_target = val_q[head_idx];
            end
         end
      end
   end

   assign alloc_ready = !full && !flush_valid;
   assign alloc_fire  = alloc_valid && alloc_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         done_q  <= '0;
         head    <= '0;
         tail    <= '0;
      end else if (flush_valid) begin
         valid_q <= '0;
         done_q  <= '0;
         head    <= '0;
         tail    <= '0;
      end else begin
         if (ex_valid && valid_q[rob_entry_idx]) begin
            done_q[rob_entry_idx]    <= 1'b1;
            mispred_q[rob_entry_idx] <= br_mispred;
            exc_q[rob_entry_idx]     <= exception;
            val_q[rob_entry_idx]     <= ex_val;
         end
         if (commit_valid) begin
            valid_q[head_idx] <= 1'b0;
            head              <= head + PTR_ONE;
         end
         if (alloc_fire) begin
            valid_q[tail_idx]    <= 1'b1;
            done_q[tail_idx]     <= 1'b0;
            mispred_q[tail_idx]  <= 1'b0;
            exc_q[tail_idx]      <= 1'b0;
            areg_q[tail_idx]     <= alloc_dst_areg;
            preg_q[tail_idx]     <= alloc_dst_preg;
            old_preg_q[tail_idx] <= alloc_old_preg;
            pc_q[tail_idx]       <= alloc_pc;
            tail                 <= tail + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, out-of-order writeback, mispredict and
// exception flushes, full-ROB commit with sustained alloc/commit pairs, and mid-flight reset.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alloc_valid = 1'b0;
   logic        alloc_ready;
   logic [4:0]  alloc_dst_areg = '0;
   logic [5:0]  alloc_dst_preg = '0;
   logic [5:0]  alloc_old_preg = '0;
   logic [31:0] alloc_pc = '0;
   logic [3:0]  alloc_idx;
   logic        ex_valid = 1'b0;
   logic [3:0]  rob_entry_idx = '0;
   logic [31:0] ex_val = '0;
   logic        br_mispred = 1'b0;
   logic        exception = 1'b0;
   logic        commit_valid;
   logic [4:0]  commit_dst_areg;
   logic [5:0]  commit_dst_preg;
   logic [5:0]  commit_old_preg;
   logic        flush_valid;
   logic [31:0] flush_target;
   logic [4:0]  count;

   int checks = 0;
   int errors = 0;
   logic [5:0] exp_q[$];

   reorder_buffer dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_dst_areg(alloc_dst_areg), .alloc_dst_preg(alloc_dst_preg),
      .alloc_old_preg(alloc_old_preg), .alloc_pc(alloc_pc), .alloc_idx(alloc_idx),
      .ex_valid(ex_valid), .rob_entry_idx(rob_entry_idx), .ex_val(ex_val),
      .br_mispred(br_mispred), .exception(exception),
      .commit_valid(commit_valid), .commit_dst_areg(commit_dst_areg),
      .commit_dst_preg(commit_dst_preg), .commit_old_preg(commit_old_preg),
      .flush_valid(flush_valid), .flush_target(flush_target), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alloc_valid = 1'b0;
      ex_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_alloc(input logic [4:0] a, input logic [5:0] p, input logic [5:0] o,
                           input logic [31:0] pc);
      alloc_valid = 1'b1;
      alloc_dst_areg = a;
      alloc_dst_preg = p;
      alloc_old_preg = o;
      alloc_pc = pc;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_wb(input logic [3:0] idx, input logic [31:0] v, input logic mis,
                        input logic exc);
      ex_valid = 1'b1;
      rob_entry_idx = idx;
      ex_val = v;
      br_mispred = mis;
      exception = exc;
      tick();
      ex_valid = 1'b0;
      br_mispred = 1'b0;
      exception = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
      checks++; if (alloc_idx !== 4'd0) begin errors++; $display("FAIL reset_alloc_idx got %0d exp 0", alloc_idx); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (commit_valid !== 1'b0 || flush_valid !== 1'b0) begin errors++; $display("FAIL reset_valids got commit=%0b flush=%0b exp 0 0", commit_valid, flush_valid); end
      checks++; if (commit_old_preg !== 6'd0 || commit_dst_preg !== 6'd0 || commit_dst_areg !== 5'd0 || flush_target !== 32'd0) begin errors++; $display("FAIL reset_fields got old=%0d preg=%0d areg=%0d tgt=%h exp zeros", commit_old_preg, commit_dst_preg, commit_dst_areg, flush_target); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         checks++; if (alloc_idx !== 4'(i) || alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_idx[%0d] got idx=%0d rdy=%0b exp idx=%0d rdy=1", i, alloc_idx, alloc_ready, i); end
         do_alloc(5'(i), 6'(i + 1), 6'(i + 32), 32'(i * 4));
      end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count); end
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b exp 0", alloc_ready); end
      checks++; if (alloc_idx !== 4'd0) begin errors++; $display("FAIL fill_idx_wrap got %0d exp 0", alloc_idx); end
      do_alloc(5'd1, 6'd2, 6'd3, 32'h44);
      checks++; if (count !== 5'd16 || commit_valid !== 1'b0) begin errors++; $display("FAIL fill_17th got count=%0d commit=%0b exp 16 0", count, commit_valid); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         do_alloc(5'(i + 1), 6'(i + 20), 6'(i + 10), 32'h1000 + 32'(i * 4));
         exp_q.push_back(6'(i + 10));
      end
      do_wb(4'd2, 32'h22, 1'b0, 1'b0);
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_early_commit got %0b exp 0", commit_valid); end
      do_wb(4'd0, 32'h20, 1'b0, 1'b0);
      checks++; if (commit_valid !== 1'b1 || commit_old_preg !== exp_q[0]) begin errors++; $display("FAIL ooo_commit0 got v=%0b old=%0d exp v=1 old=%0d", commit_valid, commit_old_preg, exp_q[0]); end
      checks++; if (commit_dst_areg !== 5'd1 || commit_dst_preg !== 6'd20) begin errors++; $display("FAIL ooo_commit0_fields got areg=%0d preg=%0d exp 1 20", commit_dst_areg, commit_dst_preg); end
      void'(exp_q.pop_front());
      do_wb(4'd1, 32'h21, 1'b0, 1'b0);
      checks++; if (commit_valid !== 1'b1 || commit_old_preg !== exp_q[0]) begin errors++; $display("FAIL ooo_commit1 got v=%0b old=%0d exp v=1 old=%0d", commit_valid, commit_old_preg, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
      checks++; if (commit_valid !== 1'b1 || commit_old_preg !== exp_q[0]) begin errors++; $display("FAIL ooo_commit2 got v=%0b old=%0d exp v=1 old=%0d", commit_valid, commit_old_preg, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
      checks++; if (count !== 5'd0 || commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained got count=%0d v=%0b exp 0 0", count, commit_valid); end
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(5'(i + 4), 6'(i + 40), 6'(i + 50), 32'h10 + 32'(i * 4));
      do_wb(4'd1, 32'h100, 1'b1, 1'b0);
      checks++; if (commit_valid !== 1'b0 || flush_valid !== 1'b0) begin errors++; $display("FAIL mis_wait got v=%0b f=%0b exp 0 0", commit_valid, flush_valid); end
      do_wb(4'd0, 32'h5, 1'b0, 1'b0);
      checks++; if (commit_valid !== 1'b1 || flush_valid !== 1'b0 || commit_old_preg !== 6'd50) begin errors++; $display("FAIL mis_commit0 got v=%0b f=%0b old=%0d exp 1 0 50", commit_valid, flush_valid, commit_old_preg); end
      tick();
      checks++; if (commit_valid !== 1'b1 || flush_valid !== 1'b1 || flush_target !== 32'h100 || commit_old_preg !== 6'd51) begin errors++; $display("FAIL mis_flush got v=%0b f=%0b tgt=%h old=%0d exp 1 1 100 51", commit_valid, flush_valid, flush_target, commit_old_preg); end
      checks++; if (alloc_ready !== 1'b0 || count !== 5'd3) begin errors++; $display("FAIL mis_flush_ready got rdy=%0b count=%0d exp 0 3", alloc_ready, count); end
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      checks++; if (count !== 5'd0 || flush_valid !== 1'b0 || commit_valid !== 1'b0 || alloc_idx !== 4'd0) begin errors++; $display("FAIL mis_after got count=%0d f=%0b v=%0b idx=%0d exp 0 0 0 0", count, flush_valid, commit_valid, alloc_idx); end
      do_wb(4'd2, 32'h7, 1'b0, 1'b0);
      do_wb(4'd3, 32'h8, 1'b0, 1'b0);
      checks++; if (commit_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL mis_squashed got v=%0b count=%0d exp 0 0", commit_valid, count); end
   endtask

   task automatic test_exception();
      do_reset();
      do_alloc(5'd9, 6'd30, 6'd31, 32'h40);
      do_wb(4'd0, 32'hdead, 1'b0, 1'b1);
      checks++; if (commit_valid !== 1'b0 || flush_valid !== 1'b1 || flush_target !== 32'h40) begin errors++; $display("FAIL exc_flush got v=%0b f=%0b tgt=%h exp 0 1 40", commit_valid, flush_valid, flush_target); end
      tick();
      checks++; if (count !== 5'd0 || flush_valid !== 1'b0) begin errors++; $display("FAIL exc_after got count=%0d f=%0b exp 0 0", count, flush_valid); end
   endtask

   task automatic test_back_to_back();
      int cnt_exp;
      do_reset();
      for (int i = 0; i < 16; i++) do_alloc(5'(i), 6'(i), 6'(i), 32'(i));
      do_wb(4'd0, 32'h0, 1'b0, 1'b0);
      checks++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_commit got v=%0b rdy=%0b exp 1 0", commit_valid, alloc_ready); end
      alloc_valid = 1'b1;
      tick();
      checks++; if (count !== 5'd15 || alloc_ready !== 1'b1) begin errors++; $display("FAIL b2b_refused got count=%0d rdy=%0b exp 15 1", count, alloc_ready); end
      tick();
      alloc_valid = 1'b0;
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL b2b_accepted got count=%0d exp 16", count); end

      // Pipelined pairs: alloc entry k, write back entry k-1, entry k-2 commits.
      do_reset();
      exp_q.delete();
      for (int k = 0; k <= 42; k++) begin
         cnt_exp = ((k < 40) ? k : 40) - ((k > 2) ? (k - 2) : 0);
         checks++; if (count !== 5'(cnt_exp)) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp %0d", k, count, cnt_exp); end
         if (k >= 2 && k <= 41) begin
            checks++;
            if (commit_valid !== 1'b1 || exp_q.size() == 0 || commit_old_preg !== exp_q[0]) begin
               errors++; $display("FAIL b2b_commit[%0d] got v=%0b old=%0d exp v=1 old=%0d", k, commit_valid, commit_old_preg, k - 2);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end else begin
            checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got v=%0b exp 0", k, commit_valid); end
         end
         alloc_valid = (k < 40);
         alloc_old_preg = 6'(k);
         alloc_dst_preg = 6'(k + 1);
         alloc_dst_areg = 5'(k);
         if (k < 40) begin
            checks++; if (alloc_idx !== 4'(k) || alloc_ready !== 1'b1) begin errors++; $display("FAIL b2b_alloc_idx[%0d] got %0d rdy=%0b exp %0d 1", k, alloc_idx, alloc_ready, k % 16); end
            exp_q.push_back(6'(k));
         end
         ex_valid = (k >= 1 && k <= 40);
         rob_entry_idx = 4'(k - 1);
         ex_val = 32'(k);
         tick();
      end
      alloc_valid = 1'b0;
      ex_valid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      for (int i = 0; i < 8; i++) do_alloc(5'(i), 6'(i), 6'(i), 32'(i));
      rst = 1'b1;
      alloc_valid = 1'b1;
      ex_valid = 1'b1;
      rob_entry_idx = 4'd0;
      tick();
      rst = 1'b0;
      alloc_valid = 1'b0;
      ex_valid = 1'b0;
      checks++; if (count !== 5'd0 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin errors++; $display("FAIL rst_mid_state got count=%0d rdy=%0b idx=%0d exp 0 1 0", count, alloc_ready, alloc_idx); end
      checks++; if (commit_valid !== 1'b0 || flush_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valids got v=%0b f=%0b exp 0 0", commit_valid, flush_valid); end
      tick();
      checks++; if (commit_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rst_mid_after got v=%0b count=%0d exp 0 0", commit_valid, count); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_out_of_order();
      test_mispredict();
      test_exception();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
